csr: RTL and testbench
======================

Name: csr

Overview:
- Machine-mode CSR file plus trap/PC sequencer for the unpipelined RV32 core.
- Decodes SYSTEM instructions: ECALL, EBREAK, MRET, and CSRRx/CSRRxI.
- Arbitrates external, timer and software interrupts, and owns the program counter, selecting between sequential, trap-vector and MRET return targets.

Parameters:
- RESET_PC, 32'h0000_0000, program_counter value after reset.
- MTVEC_RESET, 32'h0000_0100, mtvec reset value (bits[1:0]=00, direct mode).
- MIE_RESET, 32'h0000_0888, mie reset value (MEIE, MTIE, MSIE set).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instruction  in  32  instruction at program_counter.
- irq_external  in  1  level machine external interrupt.
- irq_timer  in  1  level machine timer interrupt.
- irq_software  in  1  level machine software interrupt.
- clock_enable  in  1  advance enable; 0 freezes all state.
- csr_data_out  out  32  old value of the addressed CSR (rd data).
- ebreak  out  1  instruction decodes as EBREAK.
- ecall  out  1  instruction decodes as ECALL.
- mcause  out  32  mcause register.
- mcause_cause_code  out  4  mcause[3:0].
- trap_address  out  32  trap target computed from mtvec.
- program_counter  out  32  current PC register.
- program_counter_source  out  2  selects the next-PC source: 00 PC+4, 01 trap_address, 10 mepc, 11 hold.
- next_program_counter  out  32  value the PC loads at the next enabled edge.
- instruction_address  out  32  equals program_counter.
- prev_instruction_address  out  32  PC of the previously retired instruction.
- next_address  out  32  program_counter+4.
- take_trap  out  1  trap is being taken this cycle.
- current_state  out  4  FSM state register.
- next_state  out  4  combinational next FSM state.

Behaviour:
- Reset (async, reset_n=0):
  - program_counter=RESET_PC and prev_instruction_address=0.
  - mstatus=0 (MIE=0, MPIE=0, MPP=2'b11 read-only), mie=MIE_RESET, mtvec=MTVEC_RESET.
  - mepc, mcause, mtval and mscratch=0.
  - current_state=S_RESET.
  - All registered outputs are 0 except program_counter.
- Decode: opcode 7'b1110011.
  - ECALL=32'h00000073, EBREAK=32'h00100073, MRET=32'h30200073.
  - funct3 001/010/011 are CSRRW/S/C; funct3 101/110/111 are the immediate forms with zimm=instruction[19:15].
  - Any other instruction is a no-op for this block; PC advances by 4.
- CSRs implemented:
  - mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343.
  - mip 0x344 is read-only: {irq_external@11, irq_timer@7, irq_software@3}.
  - Unimplemented addresses read 0 and ignore writes.
- CSR instruction semantics:
  - csr_data_out = old CSR value (combinational).
  - Immediate forms write on the enabled edge: RW writes zimm, RS writes old|zimm, RC writes old&~zimm. RS/RC with zimm=0 do not write.
  - Register forms are read-only in this block, since no rs1 data port exists.
  - mepc[1:0] and mtvec[1] are forced to 0.
- Trap detection (combinational), valid only in S_RUN with clock_enable=1:
  - An interrupt is pending when mstatus.MIE and (mip&mie) are nonzero.
  - Priority: external (cause 11) > software (3) > timer (7), all with mcause[31]=1.
  - Interrupts outrank synchronous exceptions: ECALL (cause 11, mcause[31]=0) and EBREAK (cause 3).
  - take_trap = interrupt pending OR ecall OR ebreak.
- trap_address:
  - Direct mode (mtvec[0]=0): {mtvec[31:2],2'b00}.
  - Vectored mode (mtvec[0]=1): base + 4×cause, applied to interrupts only.
- Trap entry on the enabled edge:
  - mepc<=program_counter, mcause<=cause, mtval<=0.
  - MPIE<=MIE, MIE<=0.
  - PC<=trap_address, with program_counter_source=01.
- MRET (in S_RUN, no pending interrupt):
  - PC<=mepc, MIE<=MPIE, MPIE<=1, with program_counter_source=10.
  - MRET returns to mepc itself; software adds 4 to skip ECALL.
- Otherwise program_counter_source=00 and next_program_counter=program_counter+4.
- On each enabled edge, prev_instruction_address<=program_counter.
- FSM encoding: S_RESET=0, S_RUN=1, S_TRAP=2, S_MRET=3.
  - S_RESET→S_RUN on the first enabled edge; the PC holds in S_RESET (source 11).
  - S_RUN→S_TRAP when take_trap; S_RUN→S_MRET on MRET; otherwise S_RUN stays.
  - S_TRAP and S_MRET→S_RUN after one cycle. Interrupts are masked during these states, and the instruction at the new PC executes normally.
- clock_enable=0: no state changes, take_trap=0, combinational outputs remain valid.

Decomposition:
- Shared package csr_pkg holds:
  - CSR address constants and mcause codes.
  - SYSTEM opcode and funct3 codes.
  - FSM state encodings and program_counter_source encodings.
- Natural sub-module: csr_trap_arbiter, covering interrupt priority, cause and trap_address.

Test Plan:
- Reset, then ECALL at PC 0 → take_trap=1, ecall=1, next_program_counter=0x100, source=01. Next cycle: mcause=11, mcause_cause_code=11, mepc=0, current_state=2.
- MRET following ECALL → source=10, PC returns to 0, MIE restored from MPIE, current_state=3 then 1.
- EBREAK at PC 8 → mcause=3, mepc=8, PC=0x100.
- CSRRSI mstatus,8 → MIE=1, csr_data_out=old value. Then irq_timer=1 → mcause=0x80000007, MIE=0, MPIE=1.
- irq_external, irq_timer and irq_software asserted together with ECALL and MIE=1 → mcause=0x8000000B.
- clock_enable=0 while ECALL is present → PC, mcause and state unchanged, take_trap=0. Asserting reset_n=0 mid-trap → PC=0, current_state=0 immediately.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file and trap/PC sequencer:
// SYSTEM decode constants, CSR addresses, cause codes and FSM encodings.
package csr_pkg;

  // SYSTEM opcode and the fixed encodings of the privileged instructions
  localparam logic [6:0]  OPCODE_SYSTEM = 7'b1110011;
  localparam logic [31:0] INSN_ECALL    = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK   = 32'h0010_0073;
  localparam logic [31:0] INSN_MRET     = 32'h3020_0073;

  // funct3 codes of the Zicsr instructions
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  // Implemented CSR addresses
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  // mstatus / mip / mie bit positions
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int IRQ_SOFTWARE_BIT = 3;
  localparam int IRQ_TIMER_BIT    = 7;
  localparam int IRQ_EXTERNAL_BIT = 11;

  // mcause exception codes (interrupt flag carried separately in bit 31)
  localparam logic [3:0] CAUSE_M_SOFTWARE = 4'd3;
  localparam logic [3:0] CAUSE_M_TIMER    = 4'd7;
  localparam logic [3:0] CAUSE_M_EXTERNAL = 4'd11;
  localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_M    = 4'd11;

  // Sequencer states
  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_RUN   = 4'd1,
    S_TRAP  = 4'd2,
    S_MRET  = 4'd3
  } state_t;

  // Next-PC source select
  typedef enum logic [1:0] {
    PC_SRC_SEQ  = 2'b00,
    PC_SRC_TRAP = 2'b01,
    PC_SRC_MEPC = 2'b10,
    PC_SRC_HOLD = 2'b11
  } pc_src_t;

  // New CSR value produced by an immediate-form CSR instruction
  function automatic logic [31:0] csr_imm_result(input logic [2:0]  funct3,
                                                 input logic [31:0] old_value,
                                                 input logic [4:0]  zimm);
    logic [31:0] zext;
    logic [31:0] result;
    zext = {27'd0, zimm};
    case (funct3)
      F3_CSRRWI: result = zext;
      F3_CSRRSI: result = old_value | zext;
      default:   result = old_value & ~zext;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/csr_trap_arbiter.sv
// Interrupt priority, trap cause selection and trap target computation.
module csr_trap_arbiter
  import csr_pkg::*;
(
  input  logic [31:0] mip,
  input  logic [31:0] mie,
  input  logic [31:0] mtvec,
  input  logic        global_ie,
  input  logic        active,
  input  logic        ecall,
  input  logic        ebreak,
  output logic        take_trap,
  output logic [31:0] cause,
  output logic [31:0] trap_address
);

  logic [31:0] pending;
  logic        interrupt_pending;
  logic [31:0] trap_base;

  assign pending           = mip & mie;
  assign interrupt_pending = global_ie && (pending != 32'd0);

  // Interrupts outrank exceptions; among interrupts external > software > timer
  always_comb begin
    cause = {1'b0, 27'd0, CAUSE_BREAKPOINT};
    if (interrupt_pending) begin
      if (pending[IRQ_EXTERNAL_BIT]) begin
        cause = {1'b1, 27'd0, CAUSE_M_EXTERNAL};
      end else if (pending[IRQ_SOFTWARE_BIT]) begin
        cause = {1'b1, 27'd0, CAUSE_M_SOFTWARE};
      end else begin
        cause = {1'b1, 27'd0, CAUSE_M_TIMER};
      end
    end else if (ecall) begin
      cause = {1'b0, 27'd0, CAUSE_ECALL_M};
    end
  end

  assign take_trap = active && (interrupt_pending || ecall || ebreak);

  // Vectored mode offsets only interrupts; exceptions always land on the base
  assign trap_base    = {mtvec[31:2], 2'b00};
  assign trap_address = (mtvec[0] && interrupt_pending)
                        ? trap_base + {26'd0, cause[3:0], 2'b00}
                        : trap_base;

endmodule

// File: rtl/csr.sv
// Machine-mode CSR file and trap/PC sequencer for the unpipelined RV32 core.
module csr
  import csr_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter logic [31:0] MIE_RESET   = 32'h0000_0888
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] instruction,
  input  logic        irq_external,
  input  logic        irq_timer,
  input  logic        irq_software,
  input  logic        clock_enable,
  output logic [31:0] csr_data_out,
  output logic        ebreak,
  output logic        ecall,
  output logic [31:0] mcause,
  output logic [3:0]  mcause_cause_code,
  output logic [31:0] trap_address,
  output logic [31:0] program_counter,
  output logic [1:0]  program_counter_source,
  output logic [31:0] next_program_counter,
  output logic [31:0] instruction_address,
  output logic [31:0] prev_instruction_address,
  output logic [31:0] next_address,
  output logic        take_trap,
  output logic [3:0]  current_state,
  output logic [3:0]  next_state
);

  state_t      state_reg;
  state_t      state_next;
  pc_src_t     pc_source;
  logic [31:0] pc_reg;
  logic [31:0] prev_pc_reg;
  logic        mstatus_mie_reg;
  logic        mstatus_mpie_reg;
  logic [31:0] mie_reg;
  logic [31:0] mtvec_reg;
  logic [31:0] mscratch_reg;
  logic [31:0] mepc_reg;
  logic [31:0] mcause_reg;
  logic [31:0] mtval_reg;

  logic        is_mret;
  logic        is_csr;
  logic        csr_write;
  logic        run_active;
  logic        do_mret;
  logic [2:0]  funct3;
  logic [11:0] csr_addr;
  logic [4:0]  zimm;
  logic [31:0] mip_value;
  logic [31:0] mstatus_value;
  logic [31:0] csr_read_value;
  logic [31:0] csr_new;
  logic [31:0] trap_cause;

  // ---------------------------------------------------------------- decode
  assign funct3   = instruction[14:12];
  assign csr_addr = instruction[31:20];
  assign zimm     = instruction[19:15];
  assign ecall    = (instruction == INSN_ECALL);
  assign ebreak   = (instruction == INSN_EBREAK);
  assign is_mret  = (instruction == INSN_MRET);

  // Recognise the six Zicsr encodings under the SYSTEM opcode
  always_comb begin
    is_csr = 1'b0;
    if (instruction[6:0] == OPCODE_SYSTEM) begin
      case (funct3)
        F3_CSRRW, F3_CSRRS, F3_CSRRC,
        F3_CSRRWI, F3_CSRRSI, F3_CSRRCI: is_csr = 1'b1;
        default:                         is_csr = 1'b0;
      endcase
    end
  end

  // ------------------------------------------------------------- CSR read
  assign mip_value = (32'(irq_external) << IRQ_EXTERNAL_BIT)
                   | (32'(irq_timer)    << IRQ_TIMER_BIT)
                   | (32'(irq_software) << IRQ_SOFTWARE_BIT);

  // Only MIE and MPIE are stored; MPP is hardwired to machine mode (11)
  assign mstatus_value = {19'd0, 2'b11, 3'd0, mstatus_mpie_reg, 3'd0, mstatus_mie_reg, 3'd0};

  // Old value of the addressed CSR; unimplemented addresses read zero
  always_comb begin
    case (csr_addr)
      CSR_MSTATUS:  csr_read_value = mstatus_value;
      CSR_MIE:      csr_read_value = mie_reg;
      CSR_MTVEC:    csr_read_value = mtvec_reg;
      CSR_MSCRATCH: csr_read_value = mscratch_reg;
      CSR_MEPC:     csr_read_value = mepc_reg;
      CSR_MCAUSE:   csr_read_value = mcause_reg;
      CSR_MTVAL:    csr_read_value = mtval_reg;
      CSR_MIP:      csr_read_value = mip_value;
      default:      csr_read_value = 32'd0;
    endcase
  end

  assign csr_data_out = is_csr ? csr_read_value : 32'd0;
  assign csr_new      = csr_imm_result(funct3, csr_read_value, zimm);

  // ------------------------------------------------------------- trap path
  assign run_active = clock_enable && (state_reg == S_RUN);

  csr_trap_arbiter u_trap_arbiter (
    .mip          (mip_value),
    .mie          (mie_reg),
    .mtvec        (mtvec_reg),
    .global_ie    (mstatus_mie_reg),
    .active       (run_active),
    .ecall        (ecall),
    .ebreak       (ebreak),
    .take_trap    (take_trap),
    .cause        (trap_cause),
    .trap_address (trap_address)
  );

  // MRET cannot coexist with an exception, so !take_trap means "no interrupt"
  assign do_mret = run_active && is_mret && !take_trap;

  // Register forms have no rs1 data here, so only immediate forms write;
  // set/clear with a zero immediate leaves the CSR untouched.
  assign csr_write = clock_enable && (state_reg != S_RESET) && !take_trap
                   && is_csr && funct3[2]
                   && ((funct3 == F3_CSRRWI) || (zimm != 5'd0));

  // Next-PC source and next FSM state
  always_comb begin
    pc_source  = PC_SRC_SEQ;
    state_next = state_reg;
    if (!clock_enable || (state_reg == S_RESET)) begin
      pc_source = PC_SRC_HOLD;
    end else if (take_trap) begin
      pc_source = PC_SRC_TRAP;
    end else if (do_mret) begin
      pc_source = PC_SRC_MEPC;
    end
    if (clock_enable) begin
      case (state_reg)
        S_RESET: state_next = S_RUN;
        S_RUN: begin
          if (take_trap) begin
            state_next = S_TRAP;
          end else if (do_mret) begin
            state_next = S_MRET;
          end else begin
            state_next = S_RUN;
          end
        end
        S_TRAP:  state_next = S_RUN;
        S_MRET:  state_next = S_RUN;
        default: state_next = S_RESET;
      endcase
    end
  end

  // Next-PC mux driven by the selected source
  always_comb begin
    case (pc_source)
      PC_SRC_TRAP: next_program_counter = trap_address;
      PC_SRC_MEPC: next_program_counter = mepc_reg;
      PC_SRC_HOLD: next_program_counter = pc_reg;
      default:     next_program_counter = pc_reg + 32'd4;
    endcase
  end

  // Sequencer FSM: state, program counter and previous-PC registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_RESET;
      pc_reg      <= RESET_PC;
      prev_pc_reg <= 32'd0;
    end else if (clock_enable) begin
      state_reg   <= state_next;
      pc_reg      <= next_program_counter;
      prev_pc_reg <= pc_reg;
    end
  end

  // CSR state: trap entry, MRET restore, or an immediate-form CSR write
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mstatus_mie_reg  <= 1'b0;
      mstatus_mpie_reg <= 1'b0;
      mie_reg          <= MIE_RESET;
      mtvec_reg        <= MTVEC_RESET;
      mscratch_reg     <= 32'd0;
      mepc_reg         <= 32'd0;
      mcause_reg       <= 32'd0;
      mtval_reg        <= 32'd0;
    end else if (clock_enable) begin
      if (take_trap) begin
        mepc_reg         <= pc_reg;
        mcause_reg       <= trap_cause;
        mtval_reg        <= 32'd0;
        mstatus_mpie_reg <= mstatus_mie_reg;
        mstatus_mie_reg  <= 1'b0;
      end else if (do_mret) begin
        mstatus_mie_reg  <= mstatus_mpie_reg;
        mstatus_mpie_reg <= 1'b1;
      end else if (csr_write) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mstatus_mie_reg  <= csr_new[MSTATUS_MIE_BIT];
            mstatus_mpie_reg <= csr_new[MSTATUS_MPIE_BIT];
          end
          CSR_MIE:      mie_reg      <= csr_new;
          CSR_MTVEC:    mtvec_reg    <= {csr_new[31:2], 1'b0, csr_new[0]};
          CSR_MSCRATCH: mscratch_reg <= csr_new;
          CSR_MEPC:     mepc_reg     <= {csr_new[31:2], 2'b00};
          CSR_MCAUSE:   mcause_reg   <= csr_new;
          CSR_MTVAL:    mtval_reg    <= csr_new;
          default:      ;
        endcase
      end
    end
  end

  // ------------------------------------------------------------- outputs
  assign program_counter          = pc_reg;
  assign instruction_address      = pc_reg;
  assign prev_instruction_address = prev_pc_reg;
  assign next_address             = pc_reg + 32'd4;
  assign program_counter_source   = pc_source;
  assign mcause                   = mcause_reg;
  assign mcause_cause_code        = mcause_reg[3:0];
  assign current_state            = state_reg;
  assign next_state               = state_next;

endmodule

// File: tb/tb_csr.sv
// Self-checking bench for csr: directed trap/MRET scenarios followed by
// randomized instruction/interrupt traffic against a behavioural model.
module tb_csr;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] instruction;
  logic        irq_external;
  logic        irq_timer;
  logic        irq_software;
  logic        clock_enable;
  logic [31:0] csr_data_out;
  logic        ebreak;
  logic        ecall;
  logic [31:0] mcause;
  logic [3:0]  mcause_cause_code;
  logic [31:0] trap_address;
  logic [31:0] program_counter;
  logic [1:0]  program_counter_source;
  logic [31:0] next_program_counter;
  logic [31:0] instruction_address;
  logic [31:0] prev_instruction_address;
  logic [31:0] next_address;
  logic        take_trap;
  logic [3:0]  current_state;
  logic [3:0]  next_state;

  csr dut (
    .clock                    (clock),
    .reset_n                  (reset_n),
    .instruction              (instruction),
    .irq_external             (irq_external),
    .irq_timer                (irq_timer),
    .irq_software             (irq_software),
    .clock_enable             (clock_enable),
    .csr_data_out             (csr_data_out),
    .ebreak                   (ebreak),
    .ecall                    (ecall),
    .mcause                   (mcause),
    .mcause_cause_code        (mcause_cause_code),
    .trap_address             (trap_address),
    .program_counter          (program_counter),
    .program_counter_source   (program_counter_source),
    .next_program_counter     (next_program_counter),
    .instruction_address      (instruction_address),
    .prev_instruction_address (prev_instruction_address),
    .next_address             (next_address),
    .take_trap                (take_trap),
    .current_state            (current_state),
    .next_state               (next_state)
  );

  always #5 clock = ~clock;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  // Compare one observed value against its expectation
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------------ model
  // Architectural CSRs held by address; mip is synthesised from the inputs.
  logic [31:0] csr_mem [logic [11:0]];
  logic [31:0] m_pc, m_prev, m_npc, m_cause, m_tvec, m_rdata;
  int          m_state, m_nstate, m_src;
  bit          m_take, m_domret, m_ecall, m_ebreak, m_irq;

  function automatic logic [31:0] wmask(input logic [11:0] a);
    case (a)
      12'h300: return 32'h0000_0088;
      12'h305: return 32'hFFFF_FFFD;
      12'h341: return 32'hFFFF_FFFC;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (a == 12'h344)
      v = (32'(irq_external) << 11) | (32'(irq_timer) << 7) | (32'(irq_software) << 3);
    else if (csr_mem.exists(a))
      v = csr_mem[a] | ((a == 12'h300) ? 32'h0000_1800 : 32'd0);
    return v;
  endfunction

  task automatic model_reset();
    csr_mem.delete();
    csr_mem[12'h300] = 32'd0;
    csr_mem[12'h304] = 32'h0000_0888;
    csr_mem[12'h305] = 32'h0000_0100;
    csr_mem[12'h340] = 32'd0;
    csr_mem[12'h341] = 32'd0;
    csr_mem[12'h342] = 32'd0;
    csr_mem[12'h343] = 32'd0;
    m_pc = 32'd0;
    m_prev = 32'd0;
    m_state = 0;
  endtask

  task automatic model_eval();
    logic [2:0]  f3;
    logic [31:0] pend, mstat, mtvec, base;
    bit          csr_op, active, mret;
    f3       = instruction[14:12];
    m_ecall  = (instruction == ECALL);
    m_ebreak = (instruction == EBREAK);
    mret     = (instruction == MRET);
    csr_op   = (instruction[6:0] == 7'h73) && (f3 != 3'd0) && (f3 != 3'd4);
    m_rdata  = csr_op ? model_read(instruction[31:20]) : 32'd0;
    pend     = model_read(12'h344) & csr_mem[12'h304];
    mstat    = csr_mem[12'h300];
    m_irq    = mstat[3] && (pend != 32'd0);
    if (m_irq)
      m_cause = pend[11] ? 32'h8000_000B : (pend[3] ? 32'h8000_0003 : 32'h8000_0007);
    else
      m_cause = m_ecall ? 32'd11 : 32'd3;
    mtvec  = csr_mem[12'h305];
    base   = mtvec & 32'hFFFF_FFFC;
    m_tvec = (mtvec[0] && m_irq) ? base + 4 * (m_cause & 32'hF) : base;
    active   = clock_enable && (m_state == 1);
    m_take   = active && (m_irq || m_ecall || m_ebreak);
    m_domret = active && mret && !m_take;
    if (!clock_enable || m_state == 0) begin m_src = 3; m_npc = m_pc; end
    else if (m_take)                   begin m_src = 1; m_npc = m_tvec; end
    else if (m_domret)                 begin m_src = 2; m_npc = csr_mem[12'h341]; end
    else                               begin m_src = 0; m_npc = m_pc + 4; end
    if (!clock_enable)     m_nstate = m_state;
    else if (m_state == 1) m_nstate = m_take ? 2 : (m_domret ? 3 : 1);
    else                   m_nstate = 1;
  endtask

  task automatic model_commit();
    logic [2:0]  f3;
    logic [4:0]  zimm;
    logic [11:0] addr;
    logic [31:0] old_pc, mstat, oldv, newv;
    int          old_state;
    f3 = instruction[14:12];
    zimm = instruction[19:15];
    addr = instruction[31:20];
    old_pc = m_pc;
    old_state = m_state;
    m_prev = m_pc;
    m_pc = m_npc;
    m_state = m_nstate;
    mstat = csr_mem[12'h300];
    if (m_take) begin
      csr_mem[12'h341] = old_pc;
      csr_mem[12'h342] = m_cause;
      csr_mem[12'h343] = 32'd0;
      csr_mem[12'h300] = mstat[3] ? 32'h80 : 32'h0;
    end else if (m_domret) begin
      csr_mem[12'h300] = 32'h80 | (mstat[7] ? 32'h8 : 32'h0);
    end else if (old_state != 0 && instruction[6:0] == 7'h73 && f3 >= 3'd5
                 && (f3 == 3'd5 || zimm != 5'd0)) begin
      oldv = model_read(addr);
      if (f3 == 3'd5)      newv = 32'(zimm);
      else if (f3 == 3'd6) newv = oldv | 32'(zimm);
      else                 newv = oldv & ~32'(zimm);
      if (csr_mem.exists(addr)) csr_mem[addr] = newv & wmask(addr);
    end
  endtask

  // Drive one instruction for one cycle, check every output, then advance
  task automatic run_cycle(input logic [31:0] insn, input bit e, input bit t,
                           input bit s, input bit en);
    logic [31:0] mc;
    instruction  = insn;
    irq_external = e;
    irq_timer    = t;
    irq_software = s;
    clock_enable = en;
    #2;
    model_eval();
    mc = csr_mem[12'h342];
    chk("pc",      program_counter, m_pc);
    chk("iaddr",   instruction_address, m_pc);
    chk("naddr",   next_address, m_pc + 32'd4);
    chk("prev",    prev_instruction_address, m_prev);
    chk("state",   32'(current_state), 32'(m_state));
    chk("nstate",  32'(next_state), 32'(m_nstate));
    chk("src",     32'(program_counter_source), 32'(m_src));
    chk("npc",     next_program_counter, m_npc);
    chk("take",    32'(take_trap), 32'(m_take));
    chk("ecall",   32'(ecall), 32'(m_ecall));
    chk("ebreak",  32'(ebreak), 32'(m_ebreak));
    chk("mcause",  mcause, mc);
    chk("code",    32'(mcause_cause_code), mc & 32'hF);
    chk("tvec",    trap_address, m_tvec);
    chk("rdata",   csr_data_out, m_rdata);
    $display("txn %0d insn=%h irq=%0b%0b%0b en=%0b pc=%h src=%0d take=%0b rdata=%h",
             txn, insn, e, t, s, en, program_counter, program_counter_source,
             take_trap, csr_data_out);
    txn++;
    @(posedge clock);
    if (en) model_commit();
    #1;
  endtask

  function automatic logic [31:0] csr_i(input logic [11:0] a, input logic [4:0] z,
                                        input logic [2:0] f3);
    return {a, z, f3, 5'd1, 7'h73};
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [31:0] r;
    logic [11:0] a;
    logic [2:0]  f3;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 11);
    case ($urandom_range(0, 8))
      0: a = 12'h300;
      1: a = 12'h304;
      2: a = 12'h305;
      3: a = 12'h340;
      4: a = 12'h341;
      5: a = 12'h342;
      6: a = 12'h343;
      7: a = 12'h344;
      default: a = 12'h7C0;
    endcase
    case ($urandom_range(0, 5))
      0: f3 = 3'd1;
      1: f3 = 3'd2;
      2: f3 = 3'd3;
      3: f3 = 3'd5;
      4: f3 = 3'd6;
      default: f3 = 3'd7;
    endcase
    case (k)
      0, 1: return {r[31:7], 7'h13};
      2:    return ECALL;
      3:    return EBREAK;
      4:    return MRET;
      5:    return {r[31:15], (r[0] ? 3'd4 : 3'd0), r[11:7], 7'h73};
      default: return csr_i(a, r[4:0], f3);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    instruction = NOP;
    irq_external = 1'b0;
    irq_timer = 1'b0;
    irq_software = 1'b0;
    clock_enable = 1'b1;
    model_reset();
    #12;
    chk("rst_pc",     program_counter, 32'd0);
    chk("rst_state",  32'(current_state), 32'd0);
    chk("rst_mcause", mcause, 32'd0);
    chk("rst_prev",   prev_instruction_address, 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Leave S_RESET, then ECALL at PC 0
    run_cycle(NOP, 0, 0, 0, 1);
    run_cycle(ECALL, 0, 0, 0, 1);
    chk("ecall_mcause", mcause, 32'd11);
    chk("ecall_code",   32'(mcause_cause_code), 32'd11);
    chk("ecall_state",  32'(current_state), 32'd2);
    chk("ecall_pc",     program_counter, 32'h100);
    run_cycle(csr_i(12'h341, 5'd0, 3'd2), 0, 0, 0, 1);
    run_cycle(MRET, 0, 0, 0, 1);
    chk("mret_pc",    program_counter, 32'd0);
    chk("mret_state", 32'(current_state), 32'd3);
    run_cycle(NOP, 0, 0, 0, 1);
    chk("mret_run", 32'(current_state), 32'd1);
    run_cycle(NOP, 0, 0, 0, 1);
    // EBREAK at PC 8
    run_cycle(EBREAK, 0, 0, 0, 1);
    chk("ebreak_mcause", mcause, 32'd3);
    chk("ebreak_pc",     program_counter, 32'h100);
    run_cycle(NOP, 0, 0, 0, 1);
    // Enable MIE, then a timer interrupt
    run_cycle(csr_i(12'h300, 5'd8, 3'd6), 0, 0, 0, 1);
    run_cycle(NOP, 0, 1, 0, 1);
    chk("timer_mcause", mcause, 32'h8000_0007);
    run_cycle(csr_i(12'h300, 5'd0, 3'd2), 0, 0, 0, 1);
    run_cycle(MRET, 0, 0, 0, 1);
    // All interrupts plus ECALL: masked in S_MRET, external wins in S_RUN
    run_cycle(ECALL, 1, 1, 1, 1);
    run_cycle(ECALL, 1, 1, 1, 1);
    chk("ext_mcause", mcause, 32'h8000_000B);
    run_cycle(NOP, 0, 0, 0, 1);
    // Frozen while ECALL is presented
    run_cycle(ECALL, 0, 0, 0, 0);
    run_cycle(ECALL, 0, 0, 0, 0);
    chk("freeze_pc",    program_counter, 32'h104);
    chk("freeze_state", 32'(current_state), 32'd1);
    run_cycle(ECALL, 0, 0, 0, 1);
    // Asynchronous reset in the middle of a trap
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_pc",     program_counter, 32'd0);
    chk("arst_state",  32'(current_state), 32'd0);
    chk("arst_mcause", mcause, 32'd0);
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      run_cycle(rand_insn(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
